// File: rtl/stream_avg_mc.sv
// -----------------------------------------------------------------------------
// stream_avg_mc
//
// Multi-channel streaming sum/average unit. Framed samples tagged with a channel
// ID are folded into an independent running sum and sample count per channel.
// On each frame end the sum/count are handed to a sequential restoring divider.
// The result (sum, count, average, overflow flag) then leaves on a valid/ready
// output port.
//
// Optional build macro:
//   AVG_ROUND_EN  when defined, the dividend is sum + (count>>1), which gives a
//                 round-half-up average. The divider grows by one bit, so the
//                 latency grows by one cycle. out_sum still reports the raw sum.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. The source holds its payload stable while valid is high and ready
// is low, and ready never depends on valid.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     input sample valid
//   in_ready     unit can accept a sample (only while idle)
//   in_ch        channel of the sample
//   data_first   first sample of a frame
//   data_last    last sample of a frame
//   data_in      sample value (unsigned)
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_ch       channel of the result
//   out_sum      frame sum
//   out_count    number of accepted samples in the frame
//   out_avg      frame average
//   out_ovf      frame exceeded 2^LEN_LOG2 samples, extras dropped
//   ch_busy      per-channel frame-open flags
//   err_stray    sticky: a sample hit a closed or nonexistent channel without first
//   dbg_state    current FSM state (0 idle, 1 divide, 2 output)
// -----------------------------------------------------------------------------
module stream_avg_mc #(
  parameter int NOF_BITS = 32,
  parameter int NOF_CH   = 4,
  parameter int LEN_LOG2 = 8,
  localparam int CH_W    = (NOF_CH > 1) ? $clog2(NOF_CH) : 1,
  localparam int CNT_W   = LEN_LOG2 + 1,
  localparam int SUM_W   = NOF_BITS + LEN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic                data_first,
  input  logic                data_last,
  input  logic [NOF_BITS-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [SUM_W-1:0]    out_sum,
  output logic [CNT_W-1:0]    out_count,
  output logic [NOF_BITS-1:0] out_avg,
  output logic                out_ovf,
  output logic [NOF_CH-1:0]   ch_busy,
  output logic                err_stray,
  output logic [1:0]          dbg_state
);

`ifdef AVG_ROUND_EN
  localparam int DIV_W = SUM_W + 1;
`else
  localparam int DIV_W = SUM_W;
`endif
  localparam int STEP_W = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {1'b1, {LEN_LOG2{1'b0}}};
  localparam logic [CH_W:0]    NOF_CH_L = (CH_W + 1)'(NOF_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Per-channel frame state
  logic [SUM_W-1:0] acc_q  [NOF_CH];
  logic [SUM_W-1:0] acc_d  [NOF_CH];
  logic [CNT_W-1:0] cnt_q  [NOF_CH];
  logic [CNT_W-1:0] cnt_d  [NOF_CH];
  logic [NOF_CH-1:0] open_q, open_d;
  logic [NOF_CH-1:0] ovf_q, ovf_d;
  logic              err_q, err_d;

  // Frame-end hand-off into the divider
  logic             accept;
  logic             ch_ok;
  logic             fin_go;
  logic [SUM_W-1:0] fin_sum;
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_ovf;
  logic [DIV_W-1:0] dividend;

  // Restoring divider: quo_q starts as the dividend and is shifted left one bit
  // per step while the quotient bits shift in from the right.
  logic [DIV_W-1:0]  quo_q, quo_d;
  logic [CNT_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W:0]    rem_sh;
  logic              rem_ge;
  logic              step_done;

  // Result registers
  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic [NOF_BITS-1:0] out_avg_q, out_avg_d;
  logic                out_ovf_q, out_ovf_d;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign ch_ok    = ({1'b0, in_ch} < NOF_CH_L);

  // ---------------------------------------------------------------------------
  // Per-channel accumulate / open / overflow bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    open_d  = open_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    fin_go  = 1'b0;
    fin_sum = '0;
    fin_cnt = '0;
    fin_ovf = 1'b0;
    if (accept) begin
      if (!ch_ok) begin
        err_d = 1'b1;
      end else begin
        if (data_first) begin
          // A new first discards whatever partial frame was open on this channel.
          acc_d[in_ch]  = SUM_W'(data_in);
          cnt_d[in_ch]  = CNT_W'(1);
          ovf_d[in_ch]  = 1'b0;
          open_d[in_ch] = 1'b1;
        end else if (open_q[in_ch]) begin
          if (cnt_q[in_ch] != CNT_MAX) begin
            acc_d[in_ch] = acc_q[in_ch] + SUM_W'(data_in);
            cnt_d[in_ch] = cnt_q[in_ch] + CNT_W'(1);
          end else begin
            ovf_d[in_ch] = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
        // The final values include this sample unless it was dropped above.
        if (data_last && (data_first || open_q[in_ch])) begin
          fin_go        = 1'b1;
          fin_sum       = acc_d[in_ch];
          fin_cnt       = cnt_d[in_ch];
          fin_ovf       = ovf_d[in_ch];
          acc_d[in_ch]  = '0;
          cnt_d[in_ch]  = '0;
          ovf_d[in_ch]  = 1'b0;
          open_d[in_ch] = 1'b0;
        end
      end
    end
  end

`ifdef AVG_ROUND_EN
  assign dividend = DIV_W'(fin_sum) + DIV_W'(fin_cnt >> 1);
`else
  assign dividend = fin_sum;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (fin_go)    state_d = S_DIV;
      S_DIV:   if (step_done) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider and result registers
  // ---------------------------------------------------------------------------
  assign rem_sh    = {rem_q[CNT_W-1:0], quo_q[DIV_W-1]};
  assign rem_ge    = (rem_sh >= {1'b0, dvs_q});
  // DIV_W shift steps plus one extra cycle that moves the quotient into out_avg.
  assign step_done = (step_q == STEP_W'(DIV_W));

  always_comb begin
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_avg_d   = out_avg_q;
    out_ovf_d   = out_ovf_q;
    if (fin_go) begin
      quo_d       = dividend;
      rem_d       = '0;
      dvs_d       = fin_cnt;
      step_d      = '0;
      out_ch_d    = in_ch;
      out_sum_d   = fin_sum;
      out_count_d = fin_cnt;
      out_ovf_d   = fin_ovf;
    end else if (state_q == S_DIV) begin
      if (!step_done) begin
        quo_d  = {quo_q[DIV_W-2:0], rem_ge};
        rem_d  = rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        step_d = step_q + STEP_W'(1);
      end else begin
        // The average never exceeds the largest sample, so truncation is exact.
        out_avg_d   = quo_q[NOF_BITS-1:0];
        out_valid_d = 1'b1;
      end
    end else if ((state_q == S_OUT) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '{default: '0};
      cnt_q       <= '{default: '0};
      open_q      <= '0;
      ovf_q       <= '0;
      err_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_avg_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_avg_q   <= out_avg_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_avg   = out_avg_q;
  assign out_ovf   = out_ovf_q;
  assign ch_busy   = open_q;
  assign err_stray = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_avg_mc.sv
// -----------------------------------------------------------------------------
// tb_stream_avg_mc
//
// Directed bench for stream_avg_mc (NOF_CH=4, LEN_LOG2=2, so frames hold at
// most 4 samples). A frame-level model keeps the accepted samples of each
// channel. On frame end it sums them and divides with plain arithmetic, then
// pushes the expected result into exp_q. The compare process checks every cycle
// on which out_valid is high. Literal expectations after each scenario pin the
// model itself.
// -----------------------------------------------------------------------------
module tb_stream_avg_mc;
  localparam int NOF_BITS = 32;
  localparam int NOF_CH   = 4;
  localparam int LEN_LOG2 = 2;
  localparam int CH_W     = 2;
  localparam int CNT_W    = LEN_LOG2 + 1;
  localparam int SUM_W    = NOF_BITS + LEN_LOG2;
  localparam int MAXLEN   = 1 << LEN_LOG2;
`ifdef AVG_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT   = SUM_W + 1 + RND;
  localparam int OVF_L = 0;
  localparam int AVG_L = 1;
  localparam int CNT_L = AVG_L + NOF_BITS;
  localparam int SUM_L = CNT_L + CNT_W;
  localparam int CH_L  = SUM_L + SUM_W;
  localparam int EXP_W = CH_L + CH_W;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CH_W-1:0]     in_ch = '0;
  logic                data_first = 1'b0;
  logic                data_last = 1'b0;
  logic [NOF_BITS-1:0] data_in = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CH_W-1:0]     out_ch;
  logic [SUM_W-1:0]    out_sum;
  logic [CNT_W-1:0]    out_count;
  logic [NOF_BITS-1:0] out_avg;
  logic                out_ovf;
  logic [NOF_CH-1:0]   ch_busy;
  logic                err_stray;
  logic [1:0]          dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stream_avg_mc #(.NOF_BITS(NOF_BITS), .NOF_CH(NOF_CH), .LEN_LOG2(LEN_LOG2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .data_first(data_first), .data_last(data_last), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_sum(out_sum), .out_count(out_count), .out_avg(out_avg),
    .out_ovf(out_ovf), .ch_busy(ch_busy), .err_stray(err_stray),
    .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  logic [31:0]      m_smp [NOF_CH][MAXLEN];
  int               m_len [NOF_CH];
  bit               m_open[NOF_CH];
  bit               m_ovf [NOF_CH];
  bit               m_err;
  logic [EXP_W-1:0] exp_q[$];

  function automatic void model_reset();
    for (int c = 0; c < NOF_CH; c++) begin
      m_len[c]  = 0;
      m_open[c] = 1'b0;
      m_ovf[c]  = 1'b0;
    end
    m_err = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input int ch, input bit f, input bit l, input logic [31:0] d);
    bit          was_open;
    logic [63:0] s;
    logic [63:0] a;
    int          n;
    was_open = m_open[ch];
    if (f) begin
      m_smp[ch][0] = d;
      m_len[ch]    = 1;
      m_open[ch]   = 1'b1;
      m_ovf[ch]    = 1'b0;
    end else if (was_open) begin
      if (m_len[ch] < MAXLEN) begin
        m_smp[ch][m_len[ch]] = d;
        m_len[ch]++;
      end else begin
        m_ovf[ch] = 1'b1;
      end
    end else begin
      m_err = 1'b1;
    end
    if (l && (f || was_open)) begin
      s = '0;
      n = m_len[ch];
      for (int i = 0; i < n; i++) s = s + 64'(m_smp[ch][i]);
      a = (s + 64'((RND != 0) ? (n / 2) : 0)) / 64'(n);
      exp_q.push_back({ch[CH_W-1:0], s[SUM_W-1:0], n[CNT_W-1:0], a[NOF_BITS-1:0], m_ovf[ch]});
      m_open[ch] = 1'b0;
      m_len[ch]  = 0;
      m_ovf[ch]  = 1'b0;
    end
  endfunction

  function automatic logic [NOF_CH-1:0] model_busy();
    logic [NOF_CH-1:0] b;
    for (int c = 0; c < NOF_CH; c++) b[c] = m_open[c];
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  int t_last = 0;

  task automatic send(input int ch, input bit f, input bit l, input logic [31:0] d);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      in_ch      = ch[CH_W-1:0];
      data_first = f;
      data_last  = l;
      data_in    = d;
      in_valid   = 1'b1;
      model_accept(ch, f, l, d);
      @(posedge clk);
      #1;
      if (l) t_last = cyc;
      in_valid   = 1'b0;
      data_first = 1'b0;
      data_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [EXP_W-1:0]    e;
  bit                  prev_valid = 1'b0;
  logic [CH_W-1:0]     cap_ch;
  logic [SUM_W-1:0]    cap_sum;
  logic [CNT_W-1:0]    cap_cnt;
  logic [NOF_BITS-1:0] cap_avg;
  logic                cap_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) check("latency", 64'(cyc - t_last), 64'(LAT));
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check("out_ch",    64'(out_ch),    64'(e[CH_L +: CH_W]));
          check("out_sum",   64'(out_sum),   64'(e[SUM_L +: SUM_W]));
          check("out_count", 64'(out_count), 64'(e[CNT_L +: CNT_W]));
          check("out_avg",   64'(out_avg),   64'(e[AVG_L +: NOF_BITS]));
          check("out_ovf",   64'(out_ovf),   64'(e[OVF_L]));
          if (out_ready) begin
            cap_ch  = out_ch;
            cap_sum = out_sum;
            cap_cnt = out_count;
            cap_avg = out_avg;
            cap_ovf = out_ovf;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic check_cap(input string tag, input int ch, input logic [63:0] sum,
                           input int cnt, input logic [63:0] avg, input bit ovf);
    check({tag, "_ch"},  64'(cap_ch),  64'(ch));
    check({tag, "_sum"}, 64'(cap_sum), sum);
    check({tag, "_cnt"}, 64'(cap_cnt), 64'(cnt));
    check({tag, "_avg"}, 64'(cap_avg), avg);
    check({tag, "_ovf"}, 64'(cap_ovf), 64'(ovf));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_ch_busy",   64'(ch_busy),   64'd0);
    check("rst_err",       64'(err_stray), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_avg",   64'(out_avg),   64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic three-sample frame on ch0
    send(0, 1'b1, 1'b0, 32'd10);
    send(0, 1'b0, 1'b0, 32'd20);
    send(0, 1'b0, 1'b1, 32'd30);
    wait_idle();
    check_cap("basic", 0, 64'd60, 3, 64'd20, 1'b0);

    // Interleaved ch1 / ch2
    send(1, 1'b1, 1'b0, 32'd7);
    send(2, 1'b1, 1'b0, 32'd100);
    check("busy_ch12", 64'(ch_busy), 64'b0110);
    send(1, 1'b0, 1'b1, 32'd8);
    send(2, 1'b0, 1'b1, 32'd101);
    check_cap("ilv_ch1", 1, 64'd15, 2, (RND != 0) ? 64'd8 : 64'd7, 1'b0);
    wait_idle();
    check_cap("ilv_ch2", 2, 64'd201, 2, (RND != 0) ? 64'd101 : 64'd100, 1'b0);

    // Single-sample frame at full scale on ch3
    send(3, 1'b1, 1'b1, 32'hFFFF_FFFF);
    wait_idle();
    check_cap("single", 3, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF, 1'b0);

    // Six samples into a four-sample frame
    send(0, 1'b1, 1'b0, 32'd5);
    for (int i = 0; i < 4; i++) send(0, 1'b0, 1'b0, 32'd5);
    send(0, 1'b0, 1'b1, 32'd5);
    wait_idle();
    check_cap("ovf", 0, 64'd20, 4, 64'd5, 1'b1);

    // Stray sample (with last) on idle ch2: error flag, no result
    send(2, 1'b0, 1'b1, 32'd99);
    check("stray_err", 64'(err_stray), 64'(m_err));
    check("stray_err_lit", 64'(err_stray), 64'd1);
    check("stray_no_div", 64'(in_ready), 64'd1);
    check("stray_busy", 64'(ch_busy), 64'(model_busy()));

    // Restart ch0 mid-frame with a new first
    send(0, 1'b1, 1'b0, 32'd50);
    send(0, 1'b0, 1'b0, 32'd60);
    send(0, 1'b1, 1'b0, 32'd1);
    send(0, 1'b0, 1'b1, 32'd3);
    wait_idle();
    check_cap("restart", 0, 64'd4, 2, 64'd2, 1'b0);
    check("err_sticky", 64'(err_stray), 64'd1);

    // Back-pressure: hold out_ready low for 10 cycles in OUT
    out_ready = 1'b0;
    send(1, 1'b1, 1'b0, 32'd9);
    send(1, 1'b0, 1'b1, 32'd11);
    begin
      int g;
      g = 0;
      while (!out_valid && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("hold_reach_out", 64'(out_valid), 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    check_cap("hold", 1, 64'd20, 2, 64'd10, 1'b0);

    // Reset in the middle of a division
    send(3, 1'b1, 1'b0, 32'd77);
    send(2, 1'b1, 1'b0, 32'd3);
    check("busy_pre_rst", 64'(ch_busy), 64'b1100);
    send(2, 1'b0, 1'b1, 32'd4);
    repeat (5) @(negedge clk);
    check("mid_div_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_sum",   64'(out_sum),   64'd0);
    check("mrst_out_count", 64'(out_count), 64'd0);
    check("mrst_out_avg",   64'(out_avg),   64'd0);
    check("mrst_ch_busy",   64'(ch_busy),   64'd0);
    check("mrst_err",       64'(err_stray), 64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    // Normal operation after reset
    send(1, 1'b1, 1'b0, 32'd1000);
    send(1, 1'b0, 1'b1, 32'd2000);
    wait_idle();
    check_cap("post_rst", 1, 64'd3000, 2, 64'd1500, 1'b0);
    check("final_busy", 64'(ch_busy), 64'(model_busy()));
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
